// File: rtl/frame_draw_sequencer.sv
// Frame draw sequencer: snapshots ball/platform state on start and streams one pixel write per clock.
// Optional `PLAT_ERASE_EN adds a pass that erases the previously drawn platforms before redrawing.
module frame_draw_sequencer #(
  parameter int         BALL_X     = 20,
  parameter int         BALL_SIZE  = 4,
  parameter int         PLAT_W     = 16,
  parameter int         PLAT_Y0    = 30,
  parameter int         PLAT_PITCH = 20,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter int         SCR_W      = 160,
  parameter int         SCR_H      = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  prev_ball_in,
  input  logic [7:0]  curr_ball_in,
  input  logic [2:0]  color_ball_in,
  input  logic [11:0] color_plats_in,
  input  logic [27:0] position_plats_in,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour_out,
  output logic        plot,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
);

  // Handshake: start is sampled only in IDLE; busy rises the cycle after acceptance together
  // with the first pixel, and falls when the one-cycle done pulse is raised.
  localparam int BALL_PIX = BALL_SIZE * BALL_SIZE;
  localparam int PLAT_PIX = 4 * PLAT_W;
  localparam int MAX_PIX  = (BALL_PIX > PLAT_PIX) ? BALL_PIX : PLAT_PIX;
  localparam int CW       = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
  localparam logic [CW-1:0] BALL_LAST = CW'(BALL_PIX - 1);
  localparam logic [CW-1:0] PLAT_LAST = CW'(PLAT_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ERASE_BALL = 3'd1,
    S_DRAW_BALL  = 3'd2,
    S_ERASE_PLAT = 3'd3,
    S_DRAW_PLAT  = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t        state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [7:0]    snap_prev, snap_curr, src_prev, src_curr;
  logic [2:0]    snap_cball, src_cball;
  logic [11:0]   snap_cplats, src_cplats;
  logic [27:0]   snap_pos, src_pos;
`ifdef PLAT_ERASE_EN
  logic [27:0]   last_pos;
`endif
  logic          accept, drawing, in_bounds;
  logic [8:0]    px, py;
  logic [2:0]    pcol;
  int            bi, bj, pi, pk;

  assign state_dbg = state;

  always_comb begin
    accept     = (state == S_IDLE) && start;
    // On the accepting edge the snapshot is not yet loaded, so the first pixel uses the inputs.
    src_prev   = accept ? prev_ball_in      : snap_prev;
    src_curr   = accept ? curr_ball_in      : snap_curr;
    src_cball  = accept ? color_ball_in     : snap_cball;
    src_cplats = accept ? color_plats_in    : snap_cplats;
    src_pos    = accept ? position_plats_in : snap_pos;

    nstate = state;
    ncnt   = cnt;
    case (state)
      S_IDLE: if (start) begin nstate = S_ERASE_BALL; ncnt = '0; end
      S_ERASE_BALL:
        if (cnt == BALL_LAST) begin nstate = S_DRAW_BALL; ncnt = '0; end
        else ncnt = cnt + 1'b1;
      S_DRAW_BALL:
        if (cnt == BALL_LAST) begin
`ifdef PLAT_ERASE_EN
          nstate = S_ERASE_PLAT;
`else
          nstate = S_DRAW_PLAT;
`endif
          ncnt = '0;
        end else ncnt = cnt + 1'b1;
      S_ERASE_PLAT:
        if (cnt == PLAT_LAST) begin nstate = S_DRAW_PLAT; ncnt = '0; end
        else ncnt = cnt + 1'b1;
      S_DRAW_PLAT:
        if (cnt == PLAT_LAST) begin nstate = S_DONE; ncnt = '0; end
        else ncnt = cnt + 1'b1;
      S_DONE:  nstate = S_IDLE;
      default: begin nstate = S_IDLE; ncnt = '0; end
    endcase

    // Pixel for the next cycle; sums are 9 bits so off-screen coordinates can be detected.
    bi   = int'(ncnt) % BALL_SIZE;
    bj   = int'(ncnt) / BALL_SIZE;
    pi   = int'(ncnt) % PLAT_W;
    pk   = (int'(ncnt) / PLAT_W) % 4;
    px   = '0;
    py   = '0;
    pcol = BG_COLOUR;
    case (nstate)
      S_ERASE_BALL: begin
        px = 9'(BALL_X + bi);
        py = 9'(int'(src_prev) + bj);
      end
      S_DRAW_BALL: begin
        px   = 9'(BALL_X + bi);
        py   = 9'(int'(src_curr) + bj);
        pcol = src_cball;
      end
`ifdef PLAT_ERASE_EN
      S_ERASE_PLAT: begin
        px = 9'(int'(last_pos[7*pk +: 7]) + pi);
        py = 9'(PLAT_Y0 + pk * PLAT_PITCH);
      end
`endif
      S_DRAW_PLAT: begin
        px   = 9'(int'(src_pos[7*pk +: 7]) + pi);
        py   = 9'(PLAT_Y0 + pk * PLAT_PITCH);
        pcol = src_cplats[3*pk +: 3];
      end
      default: ;
    endcase
    in_bounds = (int'(px) < SCR_W) && (int'(py) < SCR_H);
    drawing   = (nstate == S_ERASE_BALL) || (nstate == S_DRAW_BALL) ||
                (nstate == S_ERASE_PLAT) || (nstate == S_DRAW_PLAT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      snap_prev   <= '0;
      snap_curr   <= '0;
      snap_cball  <= '0;
      snap_cplats <= '0;
      snap_pos    <= '0;
      x_out       <= '0;
      y_out       <= '0;
      colour_out  <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef PLAT_ERASE_EN
      last_pos    <= '0;
`endif
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      if (accept) begin
        snap_prev   <= prev_ball_in;
        snap_curr   <= curr_ball_in;
        snap_cball  <= color_ball_in;
        snap_cplats <= color_plats_in;
        snap_pos    <= position_plats_in;
      end
      busy <= drawing;
      done <= (nstate == S_DONE);
      if (drawing) begin
        x_out      <= px[7:0];
        y_out      <= py[6:0];
        colour_out <= pcol;
        plot       <= in_bounds;
      end else begin
        plot <= 1'b0;
      end
`ifdef PLAT_ERASE_EN
      if ((nstate == S_DONE) && (state != S_DONE)) last_pos <= snap_pos;
`endif
    end
  end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Bench for frame_draw_sequencer: a reference model fills an expected pixel queue at each start,
// a negedge monitor pops and compares every busy cycle and checks done latency.
module tb_frame_draw_sequencer;

`ifdef PLAT_ERASE_EN
  localparam int N = 2*4*4 + 4*16 + 4*16;
`else
  localparam int N = 2*4*4 + 4*16;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  prev_ball_in = '0;
  logic [7:0]  curr_ball_in = '0;
  logic [2:0]  color_ball_in = '0;
  logic [11:0] color_plats_in = '0;
  logic [27:0] position_plats_in = '0;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        plot, busy, done;
  logic [2:0]  state_dbg;

  logic [18:0] exp_q[$];
  logic [18:0] e;
  logic [6:0]  m_last[4];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  int          d0;
  bit          mon_en = 1'b0;

  frame_draw_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .prev_ball_in(prev_ball_in), .curr_ball_in(curr_ball_in),
    .color_ball_in(color_ball_in), .color_plats_in(color_plats_in),
    .position_plats_in(position_plats_in),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_pix(input int x, input int y, input logic [2:0] c);
    logic       p;
    logic [7:0] xb;
    logic [6:0] yb;
    p  = (x < 160) && (y < 120);
    xb = 8'(x);
    yb = 7'(y);
    exp_q.push_back({p, xb, yb, c});
  endtask

  task automatic push_frame(input logic [7:0] prev, input logic [7:0] curr, input logic [2:0] cb,
                            input logic [11:0] cp, input logic [27:0] pos);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) push_pix(20 + i, int'(prev) + j, 3'b000);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) push_pix(20 + i, int'(curr) + j, cb);
`ifdef PLAT_ERASE_EN
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++) push_pix(int'(m_last[k]) + i, 30 + 20*k, 3'b000);
    for (int k = 0; k < 4; k++) m_last[k] = pos[7*k +: 7];
`endif
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 16; i++) push_pix(int'(pos[7*k +: 7]) + i, 30 + 20*k, cp[3*k +: 3]);
  endtask

  // Driver tasks
  task automatic start_frame(input logic [7:0] prev, input logic [7:0] curr, input logic [2:0] cb,
                             input logic [11:0] cp, input logic [27:0] pos);
    @(negedge clk);
    prev_ball_in = prev; curr_ball_in = curr; color_ball_in = cb;
    color_plats_in = cp; position_plats_in = pos;
    start = 1'b1;
    start_cyc = cyc;
    push_frame(prev, curr, cb, cp, pos);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    prev_ball_in = 8'($urandom); curr_ball_in = 8'($urandom); color_ball_in = 3'($urandom);
    color_plats_in = 12'($urandom); position_plats_in = 28'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("done_timeout", 0, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        if (exp_q.size() == 0) check("extra_pixel", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("plot", plot, e[18]);
          if (e[18]) begin
            check("x_out", x_out, e[17:10]);
            check("y_out", y_out, e[9:3]);
            check("colour_out", colour_out, e[2:0]);
          end
        end
      end else begin
        check("plot_idle", plot, 0);
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("busy_at_done", busy, 0);
        check("frame_len", exp_q.size(), 0);
        check("done_latency", cyc - start_cyc, N + 1);
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) m_last[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_colour", colour_out, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b1;
    mon_en = 1'b1;

    // Reference frame
    start_frame(8'd10, 8'd20, 3'b111, 12'b101111110001, {7'd80, 7'd70, 7'd60, 7'd50});
    wait_done();
    // Ball bottom rows clipped at y=120, and erase rows entirely off-screen
    start_frame(8'd5, 8'd118, 3'b010, 12'h5a3, {7'd0, 7'd33, 7'd99, 7'd12});
    wait_done();
    start_frame(8'd250, 8'd116, 3'b100, 12'h0f0, {7'd1, 7'd2, 7'd3, 7'd4});
    wait_done();
    // Rightmost platform positions
    start_frame(8'd0, 8'd60, 3'b011, 12'hfff, {7'd127, 7'd127, 7'd100, 7'd127});
    wait_done();

    // Reset mid-stream aborts with no done pulse
    start_frame(8'd40, 8'd41, 3'b101, 12'h123, {7'd9, 7'd19, 7'd29, 7'd39});
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_x", x_out, 0);
    check("abort_y", y_out, 0);
    check("abort_colour", colour_out, 0);
    check("abort_plot", plot, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_state", state_dbg, 0);
    reset = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 4; k++) m_last[k] = '0;
    repeat (N + 5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);

    // Starts while busy are ignored; start the cycle after done is accepted
    start_frame(8'd70, 8'd75, 3'b110, 12'habc, {7'd50, 7'd60, 7'd70, 7'd80});
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    start = 1'b1; curr_ball_in = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (44) @(negedge clk);
    start = 1'b1; prev_ball_in = 8'd99;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start_frame(8'd11, 8'd12, 3'b001, 12'h321, {7'd80, 7'd70, 7'd60, 7'd50});
    check("single_done", done_cnt - d0, 1);
    wait_done();

    // Platforms move: the next frame erases the old positions first
    start_frame(8'd30, 8'd31, 3'b010, 12'h777, {7'd40, 7'd30, 7'd20, 7'd10});
    wait_done();

    for (int r = 0; r < 3; r++) begin
      start_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                  12'($urandom_range(0, 4095)),
                  {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                   7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))});
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("idle_state", state_dbg, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
